vga_frame_checker: RTL and testbench

Passive sink on the pixel stream that `vga_controller` and `top_screen` produce. It recovers active-pixel coordinates from the `hs`, `vs` and `active_nblank` sync signals alone, measures the geometry of each line and frame, and accumulates a per-frame pixel checksum. It reports lock and geometry errors. It sits beside the HDMI/VGA output path as a hardware self-check, so frame content can be verified without writing a BMP.

---
 rtl/vga_frame_checker.sv | 222 ++++++++++++++++++++++
 tb/tb_vga_frame_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_checker.sv
// vga_frame_checker: passive monitor on the VGA pixel stream. Recovers pixel
// coordinates from the sync/blank signals alone, measures per-frame geometry,
// accumulates a per-frame colour checksum and reports lock / geometry errors.
module vga_frame_checker #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic        hs,
    input  logic        vs,
    input  logic        active_nblank,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic        pix_valid,
    output logic [9:0]  cap_x,
    output logic [9:0]  cap_y,
    output logic [11:0] cap_rgb,
    output logic        frame_done,
    output logic [31:0] frame_sum,
    output logic [9:0]  meas_width,
    output logic [9:0]  meas_height,
    output logic [9:0]  meas_htotal,
    output logic        locked,
    output logic        geom_err
);

    localparam logic [9:0] HA_W  = 10'(H_ACTIVE);
    localparam logic [9:0] VA_W  = 10'(V_ACTIVE);
    localparam logic [9:0] HT_W  = 10'(H_TOTAL);
    localparam logic [9:0] CMAX  = 10'h3FF;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
    } sample_t;

    typedef enum logic {ARM = 1'b0, RUN = 1'b1} state_t;

    sample_t     s1;
    logic        hs2, vs2, de2;
    state_t      state_q, state_d;

    logic [9:0]  x_cnt, y_cnt, h_cnt, htot, line_w, first_w;
    logic        first_seen, ragged, sat;
    logic [31:0] sum;
    logic [1:0]  gcnt;

    logic        hs_fall, vs_fall, de_rise, line_end;
    logic [9:0]  x_cur, y_inc;
    logic        x_sat_ev, y_sat_ev, h_sat_ev, rag_ev;
    logic [9:0]  f_width, f_height;
    logic        f_ragged, f_sat, good;
    logic [1:0]  gcnt_nxt;
    logic        frame_clr, frame_end;

    // S1 input capture and S2 previous-sample copy for edge detection
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1  <= '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 12'h000};
            hs2 <= 1'b1;
            vs2 <= 1'b1;
            de2 <= 1'b0;
        end else begin
            s1  <= '{hs: hs, vs: vs, de: active_nblank, rgb: {red, green, blue}};
            hs2 <= s1.hs;
            vs2 <= s1.vs;
            de2 <= s1.de;
        end
    end

    // Edge events and the geometry of the frame being closed this cycle;
    // a coincident line end is folded into the closing frame
    always_comb begin
        hs_fall  = hs2 & ~s1.hs;
        vs_fall  = vs2 & ~s1.vs;
        de_rise  = s1.de & ~de2;
        line_end = ~s1.de & de2;
        x_cur    = de_rise ? 10'd0 : x_cnt;
        x_sat_ev = s1.de && (x_cur == CMAX);
        y_sat_ev = line_end && (y_cnt == CMAX);
        h_sat_ev = !hs_fall && (h_cnt == CMAX);
        y_inc    = (y_cnt == CMAX) ? CMAX : y_cnt + 10'd1;
        rag_ev   = line_end && first_seen && (x_cnt != first_w);
        f_width  = line_end ? x_cnt : line_w;
        f_height = line_end ? y_inc : y_cnt;
        f_ragged = ragged | rag_ev;
        f_sat    = sat | y_sat_ev | h_sat_ev;
        good     = (f_width == HA_W) && (f_height == VA_W) && (htot == HT_W)
                   && !f_ragged && !f_sat;
        if (!good)
            gcnt_nxt = 2'd0;
        else if (gcnt == 2'd2)
            gcnt_nxt = 2'd2;
        else
            gcnt_nxt = gcnt + 2'd1;
    end

    // Frame FSM state register
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) state_q <= ARM;
        else          state_q <= state_d;
    end

    // Frame FSM next state: the first vs edge only arms the checker
    always_comb begin
        state_d = state_q;
        if (vs_fall) state_d = RUN;
    end

    // Frame FSM outputs: every vs edge clears, only RUN publishes results
    always_comb begin
        frame_clr = vs_fall;
        frame_end = vs_fall && (state_q == RUN);
    end

    // Horizontal sample counter, saturating
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n)   x_cnt <= '0;
        else if (s1.de) x_cnt <= (x_cur == CMAX) ? CMAX : x_cur + 10'd1;
    end

    // Line accounting: width, line count and ragged-line detection
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            line_w     <= '0;
            first_w    <= '0;
            first_seen <= 1'b0;
            ragged     <= 1'b0;
            y_cnt      <= '0;
        end else begin
            if (line_end) line_w <= x_cnt;
            if (frame_clr) begin
                y_cnt      <= '0;
                first_seen <= 1'b0;
                ragged     <= 1'b0;
            end else if (line_end) begin
                y_cnt <= y_inc;
                if (!first_seen) begin
                    first_w    <= x_cnt;
                    first_seen <= 1'b1;
                end else if (rag_ev) begin
                    ragged <= 1'b1;
                end
            end
        end
    end

    // Line period measured between hs falling edges
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            htot  <= '0;
        end else if (hs_fall) begin
            htot  <= h_cnt;
            h_cnt <= 10'd1;
        end else if (h_cnt != CMAX) begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Saturation flag; a pixel on the vs edge belongs to the new frame
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n)                             sat <= 1'b0;
        else if (frame_clr)                       sat <= x_sat_ev;
        else if (x_sat_ev | y_sat_ev | h_sat_ev)  sat <= 1'b1;
    end

    // Checksum; a pixel on the vs edge restarts the sum
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n)       sum <= '0;
        else if (frame_clr) sum <= s1.de ? {20'b0, s1.rgb} : 32'd0;
        else if (s1.de)     sum <= sum + {20'b0, s1.rgb};
    end

    // Publish per-frame results and lock status
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done  <= 1'b0;
            frame_sum   <= '0;
            meas_width  <= '0;
            meas_height <= '0;
            meas_htotal <= '0;
            geom_err    <= 1'b0;
            locked      <= 1'b0;
            gcnt        <= '0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                frame_sum   <= sum;
                meas_width  <= f_width;
                meas_height <= f_height;
                meas_htotal <= htot;
                geom_err    <= !good;
                gcnt        <= gcnt_nxt;
                locked      <= (gcnt_nxt == 2'd2);
            end
        end
    end

    // Recovered pixel output register
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid <= 1'b0;
            cap_x     <= '0;
            cap_y     <= '0;
            cap_rgb   <= '0;
        end else begin
            pix_valid <= s1.de;
            if (s1.de) begin
                cap_x   <= x_cur;
                cap_y   <= vs_fall ? 10'd0 : y_cnt;
                cap_rgb <= s1.rgb;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_checker.sv
// tb_vga_frame_checker: drives reduced-size VGA frames, predicts every
// recovered pixel and every frame result from the generated stream, and
// compares them against the checker through a scoreboard.
module tb_vga_frame_checker;

    localparam int HA = 48;
    localparam int VA = 24;
    localparam int HT = 64;
    localparam int VT = 30;

    localparam int M_NOM   = 0;
    localparam int M_RAMP  = 1;
    localparam int M_RAG   = 2;
    localparam int M_STUCK = 3;
    localparam int M_RST   = 4;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } pix_t;

    typedef struct {
        logic [31:0] sum;
        logic [9:0]  w;
        logic [9:0]  h;
        logic [9:0]  ht;
        logic        gerr;
        logic        lock;
    } frm_t;

    logic        pixel_clk, reset_n, hs, vs, active_nblank;
    logic [3:0]  red, green, blue;
    logic        pix_valid, frame_done, locked, geom_err;
    logic [9:0]  cap_x, cap_y, meas_width, meas_height, meas_htotal;
    logic [11:0] cap_rgb;
    logic [31:0] frame_sum;

    int n_chk = 0;
    int n_err = 0;
    int n_fd  = 0;
    int cyc   = 0;

    pix_t pq[$];
    frm_t fq[$];

    // model state, written only by the stimulus process
    logic        m_phs, m_pvs, m_pde, m_armed, m_first, m_rag, m_sat;
    logic [31:0] m_sum;
    int          m_run, m_runs, m_last_w, m_first_w, m_htot, m_hs_cyc, m_gcnt;

    vga_frame_checker #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT)) dut (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .hs(hs), .vs(vs),
        .active_nblank(active_nblank), .red(red), .green(green), .blue(blue),
        .pix_valid(pix_valid), .cap_x(cap_x), .cap_y(cap_y), .cap_rgb(cap_rgb),
        .frame_done(frame_done), .frame_sum(frame_sum), .meas_width(meas_width),
        .meas_height(meas_height), .meas_htotal(meas_htotal), .locked(locked),
        .geom_err(geom_err)
    );

    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phs = 1'b1; m_pvs = 1'b1; m_pde = 1'b0;
        m_armed = 1'b0; m_first = 1'b0; m_rag = 1'b0; m_sat = 1'b0;
        m_sum = '0; m_run = 0; m_runs = 0; m_last_w = 0; m_first_w = 0;
        m_htot = 0; m_hs_cyc = cyc; m_gcnt = 0;
        pq.delete();
        fq.delete();
    endtask

    task automatic model_sample(input logic h_s, input logic v_s, input logic de,
                                input logic [11:0] rgb);
        logic hsf, vsf, rise, fall, good;
        int   w;
        frm_t f;
        pix_t p;
        hsf  = m_phs & ~h_s;
        vsf  = m_pvs & ~v_s;
        rise = de & ~m_pde;
        fall = ~de & m_pde;
        if (fall) begin
            w = (m_run > 1023) ? 1023 : m_run;
            m_last_w = w;
            if (!m_first) begin
                m_first_w = w;
                m_first = 1'b1;
            end else if (w != m_first_w) begin
                m_rag = 1'b1;
            end
            if (m_runs == 1023) m_sat = 1'b1;
            else                m_runs++;
        end
        if (hsf) begin
            m_htot = (cyc - m_hs_cyc > 1023) ? 1023 : cyc - m_hs_cyc;
            m_hs_cyc = cyc;
        end
        if (vsf) begin
            if (m_armed) begin
                good = (m_last_w == HA) && (m_runs == VA) && (m_htot == HT) && !m_rag && !m_sat;
                m_gcnt = good ? ((m_gcnt == 2) ? 2 : m_gcnt + 1) : 0;
                f.sum = m_sum; f.w = 10'(m_last_w); f.h = 10'(m_runs); f.ht = 10'(m_htot);
                f.gerr = !good; f.lock = (m_gcnt == 2);
                fq.push_back(f);
            end
            m_armed = 1'b1;
            m_sum = '0; m_runs = 0; m_rag = 1'b0; m_sat = 1'b0; m_first = 1'b0;
        end
        if (de) begin
            if (rise) m_run = 0;
            p.x = 10'((m_run > 1023) ? 1023 : m_run);
            p.y = 10'(m_runs);
            p.rgb = rgb;
            pq.push_back(p);
            m_sum = m_sum + {20'b0, rgb};
            m_run++;
            if (m_run > 1023) m_sat = 1'b1;
        end
        m_phs = h_s; m_pvs = v_s; m_pde = de;
    endtask

    task automatic step(input logic h_s, input logic v_s, input logic de,
                        input logic [11:0] rgb, input logic rn);
        @(posedge pixel_clk);
        #1;
        cyc++;
        reset_n = rn; hs = h_s; vs = v_s; active_nblank = de;
        {red, green, blue} = rgb;
        if (!rn) model_reset();
        else     model_sample(h_s, v_s, de, rgb);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_sum"}, frame_sum, 0);
        check({tag, "_meas_w"}, meas_width, 0);
        check({tag, "_meas_h"}, meas_height, 0);
        check({tag, "_meas_ht"}, meas_htotal, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_geom_err"}, geom_err, 0);
    endtask

    task automatic gen_frame(input int mode);
        for (int ln = 0; ln < VT; ln++) begin
            for (int h = 0; h < HT; h++) begin
                logic        de, rn;
                logic [3:0]  n;
                logic [11:0] c;
                int          k;
                de = (h < HA) && (ln < VA);
                if (mode == M_RAG && ln == 10 && h == HA - 1) de = 1'b0;
                k = ln * HT + h - 2 * HT;
                if (mode == M_STUCK && k >= 0 && k < 1100) de = 1'b1;
                n = 4'(h);
                c = (mode == M_RAMP) ? {n, n, n} : 12'hFFF;
                rn = !(mode == M_RST && ln == 12 && h < 8);
                step(!(h >= HA + 4 && h < HA + 12), !(ln >= VA + 2 && ln < VA + 4), de, c, rn);
                if (mode == M_RST && ln == 12 && h == 0) begin
                    #2;
                    check_zero("midreset");
                end
            end
        end
    endtask

    task automatic check_nominal(input string tag);
        check({tag, "_sum"}, frame_sum, HA * VA * 4095);
        check({tag, "_width"}, meas_width, HA);
        check({tag, "_height"}, meas_height, VA);
        check({tag, "_htotal"}, meas_htotal, HT);
        check({tag, "_geom_err"}, geom_err, 0);
    endtask

    // scoreboard: compare every recovered pixel and frame result
    always @(negedge pixel_clk) begin
        pix_t p;
        frm_t f;
        if (pix_valid) begin
            if (pq.size() == 0) begin
                check("pix_unexpected", 1, 0);
            end else begin
                p = pq.pop_front();
                check("cap_x", cap_x, p.x);
                check("cap_y", cap_y, p.y);
                check("cap_rgb", cap_rgb, p.rgb);
            end
        end
        if (frame_done) begin
            n_fd++;
            if (fq.size() == 0) begin
                check("frame_unexpected", 1, 0);
            end else begin
                f = fq.pop_front();
                check("frame_sum", frame_sum, f.sum);
                check("meas_width", meas_width, f.w);
                check("meas_height", meas_height, f.h);
                check("meas_htotal", meas_htotal, f.ht);
                check("geom_err", geom_err, f.gerr);
                check("locked", locked, f.lock);
            end
        end
    end

    initial begin
        reset_n = 1'b0; hs = 1'b1; vs = 1'b1; active_nblank = 1'b0;
        red = '0; green = '0; blue = '0;
        model_reset();
        repeat (8) @(posedge pixel_clk);
        @(negedge pixel_clk);
        check_zero("reset");
        check("reset_cap_x", cap_x, 0);
        check("reset_cap_y", cap_y, 0);
        check("reset_cap_rgb", cap_rgb, 0);

        gen_frame(M_NOM);
        check("arm_no_frame_done", n_fd, 0);
        gen_frame(M_NOM);
        check_nominal("nom1");
        check("nom1_locked", locked, 0);
        gen_frame(M_NOM);
        check_nominal("nom2");
        check("nom2_locked", locked, 1);

        gen_frame(M_RAMP);
        check("ramp_geom_err", geom_err, 0);

        gen_frame(M_RAG);
        check("rag_geom_err", geom_err, 1);
        check("rag_locked", locked, 0);
        gen_frame(M_NOM);
        check_nominal("after_rag");
        check("after_rag_locked", locked, 0);

        gen_frame(M_STUCK);
        check("stuck_geom_err", geom_err, 1);
        check("stuck_locked", locked, 0);

        gen_frame(M_RST);
        gen_frame(M_NOM);
        check_nominal("after_rst");
        check("after_rst_locked", locked, 0);

        repeat (4) step(1'b1, 1'b1, 1'b0, 12'h000, 1'b1);
        @(negedge pixel_clk);
        check("frame_done_count", n_fd, 7);
        check("pix_left", pq.size(), 0);
        check("frame_left", fq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
